// File: rtl/core_out_desc_splitter.sv
// Buffers core out-descriptors in a FWFT FIFO and steers each head to the packet or DRAM-request port.
// Latency: one cycle from accept to head valid; strict FIFO order across both outputs.
// Backpressure: registered s_desc_ready = !full; a blocked head stalls all later entries. Stats: CORE_DESC_STATS_EN.
module core_out_desc_splitter #(
    parameter int          DEPTH     = 16,
    parameter logic [3:0]  TYPE_DRAM = 4'h6
`ifdef CORE_DESC_STATS_EN
    ,
    parameter int          CNT_WIDTH = 32
`endif
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       core_reset,
    input  logic [63:0]                s_desc,
    input  logic [63:0]                s_desc_dram_addr,
    input  logic                       s_desc_valid,
    output logic                       s_desc_ready,
    output logic [63:0]                m_pkt_desc,
    output logic                       m_pkt_desc_valid,
    input  logic                       m_pkt_desc_ready,
    output logic [127:0]               m_dram_req,
    output logic                       m_dram_req_valid,
    input  logic                       m_dram_req_ready,
    output logic [$clog2(DEPTH):0]     occupancy,
    output logic                       empty
`ifdef CORE_DESC_STATS_EN
    ,
    output logic [CNT_WIDTH-1:0]       stat_pkt_cnt,
    output logic [CNT_WIDTH-1:0]       stat_dram_cnt,
    output logic [CNT_WIDTH-1:0]       stat_stall_cnt
`endif
);

    localparam int           AW       = $clog2(DEPTH);
    localparam logic [AW:0]  PTR_ONE  = 1;
    localparam logic [AW:0]  PTR_FULL = {1'b1, {AW{1'b0}}};

    logic [AW:0]  wr_ptr_q, wr_ptr_d;
    logic [AW:0]  rd_ptr_q, rd_ptr_d;
    logic         ready_q, ready_d;
    logic [127:0] mem_q [DEPTH];
    logic [127:0] head;
    logic         head_is_dram;
    logic         push;
    logic         pop;

    assign head         = mem_q[rd_ptr_q[AW-1:0]];
    assign head_is_dram = (head[63:60] == TYPE_DRAM);
    assign empty        = (wr_ptr_q == rd_ptr_q);
    assign occupancy    = wr_ptr_q - rd_ptr_q;

    assign m_dram_req_valid = !empty && head_is_dram;
    assign m_pkt_desc_valid = !empty && !head_is_dram;
    assign m_dram_req       = head;
    assign m_pkt_desc       = head[63:0];

    // core_reset masks the registered ready so nothing is accepted on the flush cycle
    assign s_desc_ready = ready_q && !core_reset;

    assign push = s_desc_valid && s_desc_ready;
    assign pop  = (m_dram_req_valid && m_dram_req_ready) ||
                  (m_pkt_desc_valid && m_pkt_desc_ready);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
        if (core_reset) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end
        ready_d = ((wr_ptr_d ^ rd_ptr_d) != PTR_FULL);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            ready_q  <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            ready_q  <= ready_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q[AW-1:0]] <= {s_desc_dram_addr, s_desc};
    end

`ifdef CORE_DESC_STATS_EN
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = 1;

    logic [CNT_WIDTH-1:0] pkt_cnt_q, pkt_cnt_d;
    logic [CNT_WIDTH-1:0] dram_cnt_q, dram_cnt_d;
    logic [CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;

    // handshakes on the flush cycle are discarded, so they are not counted
    always_comb begin
        pkt_cnt_d   = pkt_cnt_q;
        dram_cnt_d  = dram_cnt_q;
        stall_cnt_d = stall_cnt_q;
        if (m_pkt_desc_valid && m_pkt_desc_ready && !core_reset) pkt_cnt_d  = pkt_cnt_q + CNT_ONE;
        if (m_dram_req_valid && m_dram_req_ready && !core_reset) dram_cnt_d = dram_cnt_q + CNT_ONE;
        if (s_desc_valid && !s_desc_ready) stall_cnt_d = stall_cnt_q + CNT_ONE;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pkt_cnt_q   <= '0;
            dram_cnt_q  <= '0;
            stall_cnt_q <= '0;
        end else begin
            pkt_cnt_q   <= pkt_cnt_d;
            dram_cnt_q  <= dram_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stat_pkt_cnt   = pkt_cnt_q;
    assign stat_dram_cnt  = dram_cnt_q;
    assign stat_stall_cnt = stall_cnt_q;
`endif

endmodule

// File: doc/core_out_desc_splitter.md
Name: core_out_desc_splitter

Overview:
Sits directly downstream of the per-core PR wrapper's out_desc/out_desc_dram_addr channel and buffers outgoing core descriptors in a small FIFO. Each descriptor is classified by its type nibble and steered to one of two consumers:
- the packet-descriptor path (scheduler/interconnect), or
- the DRAM-request path (DMA engine to host/DRAM).

It also frees the core from back-pressure of either consumer individually, and flushes on core reset.

Parameters:
DEPTH, 16, FIFO entries; power of two, 4..64
TYPE_DRAM, 4'h6, value of in_desc[63:60] that marks a DRAM-request descriptor
CNT_WIDTH, 32, width of statistics counters (optional feature only)

Ports:
clk  input  1  single clock
rst_n  input  1  synchronous active-low reset
core_reset  input  1  synchronous active-high flush of this core's queue
s_desc  input  64  descriptor from core wrapper
s_desc_dram_addr  input  64  DRAM address accompanying s_desc
s_desc_valid  input  1  descriptor valid
s_desc_ready  output  1  descriptor accepted this cycle when valid&ready
m_pkt_desc  output  64  packet descriptor out
m_pkt_desc_valid  output  1  packet descriptor valid
m_pkt_desc_ready  input  1  packet consumer ready
m_dram_req  output  128  {dram_addr, desc} out
m_dram_req_valid  output  1  DRAM request valid
m_dram_req_ready  input  1  DRAM consumer ready
occupancy  output  $clog2(DEPTH)+1  current FIFO fill level
empty  output  1  occupancy==0

Behaviour:
Reset:
- Reset is synchronous, active-low on rst_n; clock is clk.
- At rst_n=0: s_desc_ready=0, both m_*_valid=0, occupancy=0, empty=1.
- s_desc_ready goes to 1 on the first cycle after rst_n returns high.

Storage and fill:
- Circular buffer of DEPTH x 128 bits, with write/read pointers one bit wider than log2(DEPTH).
- full = pointers equal except MSB.
- s_desc_ready = !full, and is registered (no combinational path from the m_*_ready inputs).

Latency and ordering:
- First-word-fall-through. An entry written at edge N drives the selected output valid from cycle N+1 if it is at the head.
- Strict FIFO order across both outputs. A blocked head blocks later entries, including those bound for the other output (no reordering).

Steering:
- Head with desc[63:60]==TYPE_DRAM: m_dram_req_valid=1, m_dram_req={dram_addr,desc}.
- Any other head: m_pkt_desc_valid=1, m_pkt_desc=desc; the dram_addr is discarded.
- The two valids are never high together.
- Data outputs are held stable while valid&&!ready.

Pop and occupancy:
- Pop occurs when the selected valid && its ready.
- occupancy increments on push-only, decrements on pop-only, and is unchanged on simultaneous push+pop.
- Push while full is impossible (ready=0).
- Push+pop on the same cycle while full is not allowed: ready is already 0.
- Empty with a simultaneous push: the output becomes valid the next cycle, not the same cycle.

Pointer wrap:
- Pointers wrap modulo 2*DEPTH. Full/empty must be correct across wrap-around.

core_reset:
- Takes effect the next cycle: pointers cleared, occupancy=0, valids=0.
- Any push and pop on the core_reset cycle are discarded.
- s_desc_ready is forced 0 during core_reset and returns to 1 the cycle after it deasserts.
- rst_n has priority over core_reset.

Optional Feature:
CORE_DESC_STATS_EN
- Defined: adds outputs stat_pkt_cnt[CNT_WIDTH-1:0], stat_dram_cnt[CNT_WIDTH-1:0], stat_stall_cnt[CNT_WIDTH-1:0].
  - stat_pkt_cnt and stat_dram_cnt increment on each completed handshake of their output.
  - stat_stall_cnt increments each cycle s_desc_valid && !s_desc_ready.
  - All three wrap at 2^CNT_WIDTH, clear on rst_n=0, and are NOT cleared by core_reset.
- Undefined: these ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset/idle: hold rst_n=0 for 4 cycles, then release -> s_desc_ready=0 during reset and 1 on the cycle after release; valids=0; occupancy=0.
- Steering: push desc=64'h6000_0000_0000_0040 (dram_addr=64'h1_0000_2000), then desc=64'h1000_0000_0000_0080, both readies=1 -> m_dram_req=128'h0000_0001_0000_2000_6000_0000_0000_0040 one cycle after push, then m_pkt_desc=64'h1000_0000_0000_0080.
- Head-of-line blocking: m_dram_req_ready=0; push DRAM, pkt, pkt -> m_pkt_desc_valid stays 0 and occupancy=3; raise ready -> outputs emerge in push order, occupancy returns to 0.
- Full/wrap: DEPTH=16, both readies=0, push 20 valid cycles -> s_desc_ready drops after 16 accepts and occupancy=16; then drain and refill 40 entries with random readies -> every descriptor is seen once, in order, with no loss or duplication.
- core_reset mid-operation: occupancy=5, assert core_reset for 1 cycle alongside a push -> next cycle occupancy=0, valids=0; the pushed descriptor never appears.
- Stats (CORE_DESC_STATS_EN): 3 pkt, 2 DRAM, and 4 stalled cycles -> stat_pkt_cnt=3, stat_dram_cnt=2, stat_stall_cnt=4; the counts are unchanged after core_reset.
